control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 178 +++++++++++++++++
 tb/tb_control_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Microcode sequencer for an 8-bit bus CPU: steps T0..T4 and decodes control lines.
// Latency: control lines are combinational from step/opcode/flags; step advances every clk.
// Backpressure: none; only clr leaves the halted state.
module control_sequencer #(
  parameter bit SHORT_CYCLE = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  input  logic       carry,
  input  logic       zero,
  output logic [2:0] step,
  output logic       hlt,
  output logic       mi,
  output logic       ri,
  output logic       ro,
  output logic       io,
  output logic       ii,
  output logic       ai,
  output logic       ao,
  output logic       eo,
  output logic       su,
  output logic       bi,
  output logic       oi,
  output logic       ce,
  output logic       co,
  output logic       jmp,
  output logic       fi
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic eo;
    logic su;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic jmp;
    logic fi;
  } ctrl_t;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  step_t state;
  logic  halted;
  ctrl_t cw;

  // Decode the control word for the current step; flags are used live, never stored.
  always_comb begin
    cw = '0;
    if (halted) begin
      cw.hlt = 1'b1;
    end else begin
      case (state)
        T0: begin
          cw.co = 1'b1;
          cw.mi = 1'b1;
        end
        T1: begin
          cw.ro = 1'b1;
          cw.ii = 1'b1;
          cw.ce = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              cw.io = 1'b1;
              cw.mi = 1'b1;
            end
            OP_LDI: begin
              cw.io = 1'b1;
              cw.ai = 1'b1;
            end
            OP_JMP: begin
              cw.io  = 1'b1;
              cw.jmp = 1'b1;
            end
            OP_JC: begin
              cw.io  = carry;
              cw.jmp = carry;
            end
            OP_JZ: begin
              cw.io  = zero;
              cw.jmp = zero;
            end
            OP_OUT: begin
              cw.ao = 1'b1;
              cw.oi = 1'b1;
            end
            OP_HLT: cw.hlt = 1'b1;
            default: cw = '0;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              cw.ro = 1'b1;
              cw.ai = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              cw.ro = 1'b1;
              cw.bi = 1'b1;
            end
            OP_STA: begin
              cw.ao = 1'b1;
              cw.ri = 1'b1;
            end
            default: cw = '0;
          endcase
        end
        T4: begin
          case (opcode)
            OP_ADD: begin
              cw.eo = 1'b1;
              cw.ai = 1'b1;
              cw.fi = 1'b1;
            end
            OP_SUB: begin
              cw.eo = 1'b1;
              cw.ai = 1'b1;
              cw.su = 1'b1;
              cw.fi = 1'b1;
            end
            default: cw = '0;
          endcase
        end
        default: cw = '0;
      endcase
    end
  end

  // Step counter and halt latch; an empty execute step ends the instruction early when enabled.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= T0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (state == T2 && opcode == OP_HLT) begin
        halted <= 1'b1;
      end else if (SHORT_CYCLE && state >= T2 && cw == '0) begin
        state <= T0;
      end else if (state == T4) begin
        state <= T0;
      end else begin
        state <= step_t'(state + 3'd1);
      end
    end
  end

  assign step = state;
  assign {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, jmp, fi} = cw;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, JMP = 16'h0002, FI = 16'h0001;

  logic       clk = 1'b0;
  logic       clr1, clr0;
  logic [3:0] opc1, opc0;
  logic       carry, zero;
  logic [2:0] step1, step0;
  logic [15:0] w1, w0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_sequencer #(.SHORT_CYCLE(1'b1)) dut (
    .clk(clk), .clr(clr1), .opcode(opc1), .carry(carry), .zero(zero), .step(step1),
    .hlt(w1[15]), .mi(w1[14]), .ri(w1[13]), .ro(w1[12]), .io(w1[11]), .ii(w1[10]),
    .ai(w1[9]), .ao(w1[8]), .eo(w1[7]), .su(w1[6]), .bi(w1[5]), .oi(w1[4]),
    .ce(w1[3]), .co(w1[2]), .jmp(w1[1]), .fi(w1[0])
  );

  control_sequencer #(.SHORT_CYCLE(1'b0)) dut_long (
    .clk(clk), .clr(clr0), .opcode(opc0), .carry(carry), .zero(zero), .step(step0),
    .hlt(w0[15]), .mi(w0[14]), .ri(w0[13]), .ro(w0[12]), .io(w0[11]), .ii(w0[10]),
    .ai(w0[9]), .ao(w0[8]), .eo(w0[7]), .su(w0[6]), .bi(w0[5]), .oi(w0[4]),
    .ce(w0[3]), .co(w0[2]), .jmp(w0[1]), .fi(w0[0])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] cur_word(input bit sc);
    return sc ? w1 : w0;
  endfunction

  function automatic logic [2:0] cur_step(input bit sc);
    return sc ? step1 : step0;
  endfunction

  // Reference microcode table: the word an instruction should show at step i.
  function automatic logic [15:0] exp_word(input logic [3:0] op, input logic c, input logic z,
                                           input int i);
    logic [15:0] t2, t3, t4;
    t2 = 16'h0; t3 = 16'h0; t4 = 16'h0;
    case (op)
      4'h1: begin t2 = IO | MI; t3 = RO | AI; end
      4'h2: begin t2 = IO | MI; t3 = RO | BI; t4 = EO | AI | FI; end
      4'h3: begin t2 = IO | MI; t3 = RO | BI; t4 = EO | AI | SU | FI; end
      4'h4: begin t2 = IO | MI; t3 = AO | RI; end
      4'h5: t2 = IO | AI;
      4'h6: t2 = IO | JMP;
      4'h7: t2 = c ? (IO | JMP) : 16'h0;
      4'h8: t2 = z ? (IO | JMP) : 16'h0;
      4'hE: t2 = AO | OI;
      4'hF: t2 = HLT;
      default: t2 = 16'h0;
    endcase
    case (i)
      0: return CO | MI;
      1: return RO | II | CE;
      2: return t2;
      3: return t3;
      default: return t4;
    endcase
  endfunction

  task automatic check_rules(input bit sc);
    logic [15:0] w;
    w = cur_word(sc);
    check("single_bus_driver", ($countones(w & (RO | IO | AO | EO | CO)) <= 1), 1);
    check("ce_jmp_exclusive", ((w & CE) != 0) && ((w & JMP) != 0), 0);
  endtask

  task automatic set_inputs(input bit sc, input logic [3:0] op, input logic c, input logic z);
    if (sc) opc1 = op; else opc0 = op;
    carry = c;
    zero  = z;
  endtask

  task automatic set_clr(input bit sc, input logic v);
    if (sc) clr1 = v; else clr0 = v;
  endtask

  // Run one non-halting instruction starting at T0 (called just after a falling edge).
  task automatic run_instr(input bit sc, input logic [3:0] op, input logic c, input logic z);
    int len;
    bit found;
    set_inputs(sc, op, c, z);
    len = 5;
    found = 1'b0;
    if (sc) begin
      for (int i = 2; i < 5; i++) begin
        if (!found && exp_word(op, c, z, i) == 16'h0) begin
          len = i + 1;
          found = 1'b1;
        end
      end
    end
    for (int i = 0; i < len; i++) begin
      check("step", cur_step(sc), i);
      check("word", cur_word(sc), exp_word(op, c, z, i));
      check_rules(sc);
      @(negedge clk);
    end
    check("wrap_to_t0", cur_step(sc), 0);
  endtask

  // Halt instruction, freeze for 20 clocks, then async clear mid-cycle.
  task automatic run_halt(input bit sc);
    set_inputs(sc, 4'hF, carry, zero);
    for (int i = 0; i < 3; i++) begin
      check("halt_step", cur_step(sc), i);
      check("halt_word", cur_word(sc), exp_word(4'hF, 1'b0, 1'b0, i));
      if (i < 2) @(negedge clk);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("halted_step", cur_step(sc), 2);
      check("halted_word", cur_word(sc), HLT);
    end
    #2;
    set_clr(sc, 1'b1);
    #1;
    check("halt_clr_step", cur_step(sc), 0);
    check("halt_clr_word", cur_word(sc), CO | MI);
    @(negedge clk);
    check("clr_hold_step", cur_step(sc), 0);
    set_clr(sc, 1'b0);
  endtask

  task automatic run_any(input bit sc, input logic [3:0] op, input logic c, input logic z);
    if (op == 4'hF) begin
      set_inputs(sc, op, c, z);
      run_halt(sc);
    end else begin
      run_instr(sc, op, c, z);
    end
  endtask

  initial begin
    clr1 = 1'b1; clr0 = 1'b1;
    opc1 = 4'h0; opc0 = 4'h0;
    carry = 1'b0; zero = 1'b0;
    #1;
    check("reset_step", step1, 0);
    check("reset_word", w1, CO | MI);
    @(negedge clk);
    check("reset_hold_step", step1, 0);
    check("reset_hold_word", w1, CO | MI);
    check("reset_hold_step_long", step0, 0);
    clr1 = 1'b0;

    // ADD full length, then JC untaken/taken
    run_instr(1'b1, 4'h2, 1'b0, 1'b0);
    run_instr(1'b1, 4'h7, 1'b0, 1'b0);
    run_instr(1'b1, 4'h7, 1'b1, 1'b0);
    run_instr(1'b1, 4'h8, 1'b0, 1'b1);
    run_instr(1'b1, 4'h0, 1'b0, 1'b0);

    // STA aborted by clr at T3
    opc1 = 4'h4;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("sta_t3_step", step1, 3);
    check("sta_t3_word", w1, AO | RI);
    #2 clr1 = 1'b1;
    #1;
    check("sta_abort_word", w1, CO | MI);
    check("sta_abort_step", step1, 0);
    @(negedge clk);
    clr1 = 1'b0;
    run_instr(1'b1, 4'h1, 1'b0, 1'b0);

    // halt and recover
    run_halt(1'b1);
    run_instr(1'b1, 4'h3, 1'b1, 1'b1);

    // random stream on the short-cycle instance
    for (int n = 0; n < 1000; n++)
      run_any(1'b1, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));

    // long-cycle instance: LDI then random stream
    clr1 = 1'b1;
    clr0 = 1'b0;
    run_instr(1'b0, 4'h5, 1'b0, 1'b0);
    run_instr(1'b0, 4'h7, 1'b0, 1'b0);
    for (int n = 0; n < 200; n++)
      run_any(1'b0, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
